// File: rtl/vigna_bus_arbiter.sv
// Two-port to one-port bus arbiter that shares one memory port between the vigna
// instruction and data buses. Registered grant and an optional hung-transaction watchdog.
module vigna_bus_arbiter #(
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = 0
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,

  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  output logic [31:0] d_rdata,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,

  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  input  logic [31:0] m_rdata,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,

  output logic [1:0]  grant,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
  localparam logic        WD_EN       = (TIMEOUT != 0);
  localparam logic        RR_EN       = (ROUND_ROBIN != 0);

  state_e      state_q, state_d;
  logic        last_d_q, last_d_d;   // 1 when the most recent grant went to the data port
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  grant_q, grant_d;

  logic        pick_d;
  logic        is_d;
  logic        x_valid;
  logic        x_ready;
  logic [31:0] x_rdata;
  logic        timeout;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    pick_d   = 1'b0;
    is_d     = (state_q == BUSY_D);
    x_valid  = is_d ? d_valid : i_valid;
    x_ready  = 1'b0;
    x_rdata  = 32'h0;
    timeout  = WD_EN && (cnt_q == TIMEOUT_CNT);
    m_valid  = 1'b0;
    m_addr   = 32'h0;
    m_wdata  = 32'h0;
    m_wstrb  = 4'h0;
    err      = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_valid && d_valid) pick_d = RR_EN ? !last_d_q : 1'b1;
        else                    pick_d = d_valid;
        if (i_valid || d_valid) begin
          state_d  = pick_d ? BUSY_D : BUSY_I;
          grant_d  = pick_d ? 2'b10 : 2'b01;
          last_d_d = pick_d;
          cnt_d    = 16'h0;
        end
      end
      BUSY_I, BUSY_D: begin
        m_addr  = is_d ? d_addr  : i_addr;
        m_wdata = is_d ? d_wdata : i_wdata;
        m_wstrb = is_d ? d_wstrb : i_wstrb;
        x_rdata = m_rdata;
        // Abandonment wins over everything; a same-cycle m_ready beats the watchdog.
        if (!x_valid) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end else if (m_ready) begin
          m_valid = 1'b1;
          x_ready = 1'b1;
          state_d = IDLE;
          grant_d = 2'b00;
        end else if (timeout) begin
          x_ready = 1'b1;
          x_rdata = 32'h0;
          err     = 1'b1;
          state_d = IDLE;
          grant_d = 2'b00;
        end else begin
          m_valid = 1'b1;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase

    i_ready = x_ready && !is_d;
    d_ready = x_ready && is_d;
    i_rdata = is_d ? 32'h0 : x_rdata;
    d_rdata = is_d ? x_rdata : 32'h0;
  end

  assign grant = grant_q;

  // NOTE: state updates use non-blocking assignments; reset is synchronous and active-low.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      cnt_q    <= 16'h0;
      grant_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
    end
  end

endmodule

// File: tb/tb_vigna_bus_arbiter.sv
// Directed bench for vigna_bus_arbiter: a round-robin instance with a 5-cycle watchdog
// and a fixed-priority instance with the watchdog off, both driven from shared inputs.
`timescale 1ns/1ps
module tb_vigna_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_valid, d_valid, m_ready;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata, m_rdata;
  logic [3:0]  i_wstrb, d_wstrb;

  logic        r_i_ready, r_d_ready, r_m_valid, r_err;
  logic [31:0] r_i_rdata, r_d_rdata, r_m_addr, r_m_wdata;
  logic [3:0]  r_m_wstrb;
  logic [1:0]  r_grant;

  logic        f_i_ready, f_d_ready, f_m_valid, f_err;
  logic [31:0] f_i_rdata, f_d_rdata, f_m_addr, f_m_wdata;
  logic [3:0]  f_m_wstrb;
  logic [1:0]  f_grant;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vigna_bus_arbiter #(.ROUND_ROBIN(1), .TIMEOUT(5)) dut_rr (
    .clk(clk), .resetn(resetn),
    .i_valid(i_valid), .i_ready(r_i_ready), .i_addr(i_addr), .i_rdata(r_i_rdata),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb),
    .d_valid(d_valid), .d_ready(r_d_ready), .d_addr(d_addr), .d_rdata(r_d_rdata),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .m_valid(r_m_valid), .m_ready(m_ready), .m_addr(r_m_addr), .m_rdata(m_rdata),
    .m_wdata(r_m_wdata), .m_wstrb(r_m_wstrb),
    .grant(r_grant), .err(r_err)
  );

  vigna_bus_arbiter #(.ROUND_ROBIN(0), .TIMEOUT(0)) dut_fp (
    .clk(clk), .resetn(resetn),
    .i_valid(i_valid), .i_ready(f_i_ready), .i_addr(i_addr), .i_rdata(f_i_rdata),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb),
    .d_valid(d_valid), .d_ready(f_d_ready), .d_addr(d_addr), .d_rdata(f_d_rdata),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .m_valid(f_m_valid), .m_ready(m_ready), .m_addr(f_m_addr), .m_rdata(m_rdata),
    .m_wdata(f_m_wdata), .m_wstrb(f_m_wstrb),
    .grant(f_grant), .err(f_err)
  );

  // Inputs change 1ns after a rising edge; outputs are sampled 3ns later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_inputs();
    i_valid = 0; d_valid = 0; m_ready = 0; m_rdata = 32'h0;
    i_addr = 32'h0; i_wdata = 32'h0; i_wstrb = 4'h0;
    d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 0;
    next_cycle();
    next_cycle();
    resetn = 1;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    checks++; if ({r_m_valid, r_i_ready, r_d_ready, r_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl_rr: got %b exp 0000", {r_m_valid, r_i_ready, r_d_ready, r_err}); end
    checks++; if (r_grant !== 2'b00) begin
      errors++; $display("FAIL reset_grant_rr: got %b exp 00", r_grant); end
    checks++; if ({r_m_addr, r_m_wdata, r_m_wstrb} !== 68'h0) begin
      errors++; $display("FAIL reset_bus_rr: addr=%h wdata=%h wstrb=%h exp 0", r_m_addr, r_m_wdata, r_m_wstrb); end
    checks++; if ({f_m_valid, f_grant, f_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_fp: got %b exp 0000", {f_m_valid, f_grant, f_err}); end
  endtask

  task automatic test_single_fetch();
    do_reset();
    i_valid = 1; i_addr = 32'h100;
    settle();
    checks++; if (r_m_valid !== 1'b0) begin
      errors++; $display("FAIL fetch_no_comb_grant: m_valid=%b exp 0", r_m_valid); end
    next_cycle(); settle();
    checks++; if ({r_m_valid, r_grant, r_i_ready} !== 4'b1010) begin
      errors++; $display("FAIL fetch_busy1: {m_valid,grant,i_ready}=%b exp 1010", {r_m_valid, r_grant, r_i_ready}); end
    checks++; if (r_m_addr !== 32'h100) begin
      errors++; $display("FAIL fetch_addr: got %h exp 00000100", r_m_addr); end
    next_cycle(); settle();
    checks++; if ({r_m_valid, r_i_ready} !== 2'b10) begin
      errors++; $display("FAIL fetch_wait2: {m_valid,i_ready}=%b exp 10", {r_m_valid, r_i_ready}); end
    next_cycle();
    m_ready = 1; m_rdata = 32'h0000_0013;
    settle();
    checks++; if ({r_i_ready, r_d_ready} !== 2'b10) begin
      errors++; $display("FAIL fetch_ready: {i_ready,d_ready}=%b exp 10", {r_i_ready, r_d_ready}); end
    checks++; if (r_i_rdata !== 32'h13 || r_d_rdata !== 32'h0) begin
      errors++; $display("FAIL fetch_rdata: i_rdata=%h d_rdata=%h exp 00000013/00000000", r_i_rdata, r_d_rdata); end
    next_cycle();
    i_valid = 0;
    settle();
    checks++; if ({r_i_ready, r_m_valid, r_grant} !== 4'b0000) begin
      errors++; $display("FAIL fetch_done: {i_ready,m_valid,grant}=%b exp 0000", {r_i_ready, r_m_valid, r_grant}); end
    m_ready = 0;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [8] = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    do_reset();
    i_valid = 1; i_addr = 32'h200;
    d_valid = 1; d_addr = 32'h300; d_wdata = 32'hdead_beef; d_wstrb = 4'b1111;
    m_ready = 1; m_rdata = 32'h1234_5678;
    for (int c = 0; c < 8; c++) begin
      settle();
      checks++; if (r_grant !== exp_g[c]) begin
        errors++; $display("FAIL rr_grant[%0d]: got %b exp %b", c, r_grant, exp_g[c]); end
      if (exp_g[c] == 2'b10) begin
        checks++; if ({r_m_wstrb, r_m_wdata, r_d_ready, r_i_ready} !== {4'b1111, 32'hdead_beef, 2'b10}) begin
          errors++; $display("FAIL rr_store[%0d]: wstrb=%b wdata=%h d_ready=%b i_ready=%b exp 1111/deadbeef/1/0",
                             c, r_m_wstrb, r_m_wdata, r_d_ready, r_i_ready); end
      end else if (exp_g[c] == 2'b01) begin
        checks++; if ({r_m_addr, r_i_ready, r_d_ready} !== {32'h200, 2'b10}) begin
          errors++; $display("FAIL rr_fetch[%0d]: addr=%h i_ready=%b d_ready=%b exp 00000200/1/0",
                             c, r_m_addr, r_i_ready, r_d_ready); end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_fixed_priority();
    logic [1:0] exp_g [10] = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01};
    do_reset();
    i_valid = 1; i_addr = 32'h400;
    d_valid = 1; d_addr = 32'h500;
    m_ready = 1;
    for (int c = 0; c < 10; c++) begin
      if (c == 8) d_valid = 0;
      settle();
      checks++; if (f_grant !== exp_g[c]) begin
        errors++; $display("FAIL fp_grant[%0d]: got %b exp %b", c, f_grant, exp_g[c]); end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    d_valid = 1; d_addr = 32'h600; m_rdata = 32'h5555_5555;
    next_cycle();
    for (int b = 1; b <= 5; b++) begin
      settle();
      checks++; if ({r_m_valid, r_d_ready, r_err, r_grant} !== 5'b10010) begin
        errors++; $display("FAIL to_wait[%0d]: {m_valid,d_ready,err,grant}=%b exp 10010",
                           b, {r_m_valid, r_d_ready, r_err, r_grant}); end
      next_cycle();
    end
    settle();
    checks++; if ({r_m_valid, r_d_ready, r_err} !== 3'b011) begin
      errors++; $display("FAIL to_force: {m_valid,d_ready,err}=%b exp 011", {r_m_valid, r_d_ready, r_err}); end
    checks++; if (r_d_rdata !== 32'h0) begin
      errors++; $display("FAIL to_rdata: got %h exp 00000000", r_d_rdata); end
    checks++; if ({f_m_valid, f_d_ready, f_err} !== 3'b100) begin
      errors++; $display("FAIL to_disabled: {m_valid,d_ready,err}=%b exp 100", {f_m_valid, f_d_ready, f_err}); end
    next_cycle();
    d_valid = 0;
    settle();
    checks++; if ({r_err, r_m_valid, r_grant} !== 4'b0000) begin
      errors++; $display("FAIL to_idle: {err,m_valid,grant}=%b exp 0000", {r_err, r_m_valid, r_grant}); end
  endtask

  task automatic test_reset_mid_txn();
    do_reset();
    i_valid = 1; i_addr = 32'h700;
    next_cycle(); settle();
    checks++; if ({r_m_valid, r_grant} !== 3'b101) begin
      errors++; $display("FAIL rst_busy: {m_valid,grant}=%b exp 101", {r_m_valid, r_grant}); end
    resetn = 0;
    next_cycle(); settle();
    checks++; if ({r_m_valid, r_grant, r_i_ready, r_err} !== 5'b00000) begin
      errors++; $display("FAIL rst_abandon: {m_valid,grant,i_ready,err}=%b exp 00000",
                         {r_m_valid, r_grant, r_i_ready, r_err}); end
    resetn = 1;
    next_cycle(); settle();
    checks++; if ({r_m_valid, r_grant} !== 3'b101 || r_m_addr !== 32'h700) begin
      errors++; $display("FAIL rst_regrant: {m_valid,grant}=%b addr=%h exp 101/00000700",
                         {r_m_valid, r_grant}, r_m_addr); end
    m_ready = 1;
    settle();
    checks++; if ({r_i_ready, r_err} !== 2'b10) begin
      errors++; $display("FAIL rst_complete: {i_ready,err}=%b exp 10", {r_i_ready, r_err}); end
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    resetn = 0;
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_round_robin();
    test_fixed_priority();
    test_timeout();
    test_reset_mid_txn();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vigna_bus_arbiter.md
# vigna_bus_arbiter

Two-port to one-port bus arbiter that lets the vigna core's instruction bus and data bus share a single memory port. It sits between the core and a unified memory or interconnect, serialising requests with a registered grant, either round-robin or fixed data priority. An optional watchdog terminates hung transactions with an error pulse.

## Interface
- ROUND_ROBIN, 1, 1 = alternate on contention; 0 = data port always wins contention.
- TIMEOUT, 0, cycles a granted transaction may wait for m_ready before forced completion; 0 disables. Range 0..65535.
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  reset, synchronous, active-low.
- i_valid  input  1  instruction request valid.
- i_ready  output  1  instruction request complete; single-cycle pulse.
- i_addr  input  32  instruction address.
- i_rdata  output  32  instruction read data; valid while i_ready=1.
- i_wdata  input  32  instruction write data; normally 0.
- i_wstrb  input  4  instruction write strobes; normally 0.
- d_valid, d_ready, d_addr, d_rdata, d_wdata, d_wstrb  same directions and widths as the i_* ports  data port.
- m_valid  output  1  downstream request valid.
- m_ready  input  1  downstream completion.
- m_addr  output  32  downstream address.
- m_rdata  input  32  downstream read data.
- m_wdata  output  32  downstream write data.
- m_wstrb  output  4  downstream strobes; 0 = read.
- grant  output  2  one-hot owner {d,i}; 2'b00 when idle.
- err  output  1  one-cycle pulse on a timeout completion.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - Only i_valid -> BUSY_I.
  - Only d_valid -> BUSY_D.
  - Both valid, ROUND_ROBIN=1: grant the port not recorded in last_grant.
  - Both valid, ROUND_ROBIN=0: grant D.
  - Neither valid: stay in IDLE.
  - On every grant, last_grant <= granted port. last_grant resets to I, so the first contention goes to D.
- BUSY_x, combinational forwarding:
  - m_valid = x_valid; m_addr, m_wdata, m_wstrb = x_addr, x_wdata, x_wstrb.
  - x_ready = m_ready & m_valid; x_rdata = m_rdata.
  - Non-granted port: ready=0, rdata=0.
- Completion: m_valid & m_ready -> IDLE next cycle.
- Upstream abandons (granted x_valid=0 while BUSY_x) -> IDLE next cycle, no ready issued. This is a protocol violation that must be tolerated.
- Watchdog (TIMEOUT>0):
  - 16-bit counter clears on grant and increments each BUSY cycle with m_ready=0.
  - When the counter equals TIMEOUT, that cycle is a forced completion: m_valid=0, x_ready=1, x_rdata=32'h0, err=1. Next state is IDLE.
  - m_ready=1 in the same cycle as the timeout takes precedence: normal completion, err=0.
- IDLE outputs: m_valid=0, m_addr=0, m_wdata=0, m_wstrb=0, grant=0, i_ready=d_ready=0, rdata=0. m_ready is ignored.
- No buffering. Requests are held upstream until granted.

## Timing
- Reset: state=IDLE, last_grant=I, counter=0. All outputs read 0 in the cycle after the reset edge.
- resetn low mid-transaction: the transaction is abandoned, with no ready and no err. m_valid is 0 from the next cycle.
- Arbitration latency: 1 cycle. A request seen in IDLE at edge N gives m_valid=1 in cycle N+1.
- Zero-wait memory (m_ready tied 1): the x_ready pulse occurs in the first BUSY cycle. Each transaction therefore occupies 2 cycles (IDLE + BUSY).
- Back-to-back: after completion, one IDLE cycle precedes the next grant. The core drops valid on the edge after ready, so no duplicate grant occurs.
- grant is registered and changes only on state transitions.
- err is asserted only in the forced-completion cycle.

## Test plan
- Single fetch: i_valid=1, i_addr=0x100, m_ready after 2 wait cycles, m_rdata=0x00000013. Required: m_valid rises 1 cycle after i_valid; m_addr=0x100; i_ready=1 with i_rdata=0x13 for exactly one cycle; d_ready stays 0; grant=01 then 00.
- Contention, ROUND_ROBIN=1: i_valid and d_valid held high, m_ready=1. Required grants D, I, D, I. Each grant is separated by one IDLE cycle. The D store drives m_wstrb=4'b1111 and m_wdata=d_wdata.
- Contention, ROUND_ROBIN=0: both valid, 4 consecutive D requests. Required: D is granted all 4 times; I is granted only after d_valid falls.
- Timeout, TIMEOUT=5: d_valid with m_ready held 0. Required: forced completion in the 6th BUSY cycle with d_ready=1, d_rdata=0, err=1 for one cycle. m_valid=0 in that cycle; state returns to IDLE.
- Reset mid-transaction: resetn=0 while BUSY_I with m_ready=0. Required: no i_ready and no err. m_valid=0 and grant=00 after the edge. A fresh i_valid after reset gets a normal grant 1 cycle later.
